// File: rtl/alu_op_sequencer_if.sv
// Bundles the switch/button inputs, ALU drive/return signals and display outputs of the ALU front-end sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH  = 6,
  parameter int MODE_W = 3
);
  logic [WIDTH-1:0]  sw;
  logic              btn_next;
  logic              btn_clear;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [MODE_W-1:0] alu_mode;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_cout;
  logic              alu_ovf;
  logic [WIDTH-1:0]  result;
  logic              res_cout;
  logic              res_ovf;
  logic              done;
  logic [2:0]        state;

  modport master (
    output sw, btn_next, btn_clear, alu_out, alu_cout, alu_ovf,
    input  alu_a, alu_b, alu_mode, result, res_cout, res_ovf, done, state
  );

  modport slave (
    input  sw, btn_next, btn_clear, alu_out, alu_cout, alu_ovf,
    output alu_a, alu_b, alu_mode, result, res_cout, res_ovf, done, state
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Steps operand A, operand B, mode into ALU registers, then latches result HOLD_CYCLES edges after the mode step.
// All outputs registered; btn_next is ignored during EXEC (never queued), btn_clear wins over btn_next.
module alu_op_sequencer #(
  parameter int WIDTH       = 6,
  parameter int MODE_W      = 3,
  parameter int HOLD_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  alu_op_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_MODE = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    clr      = bus.btn_clear;

    case (state_q)
      S_A: if (bus.btn_next) begin
        a_d     = bus.sw;
        state_d = S_B;
      end
      S_B: if (bus.btn_next) begin
        b_d     = bus.sw;
        state_d = S_MODE;
      end
      S_MODE: if (bus.btn_next) begin
        mode_d  = bus.sw[MODE_W-1:0];
        cnt_d   = CNT_W'(HOLD_CYCLES);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Capture on the last settle edge so latency is exactly HOLD_CYCLES.
        if (cnt_q == CNT_W'(1)) begin
          result_d = bus.alu_out;
          cout_d   = bus.alu_cout;
          ovf_d    = bus.alu_ovf;
          done_d   = 1'b1;
          state_d  = S_SHOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SHOW: if (bus.btn_next) begin
        done_d  = 1'b0;
        state_d = S_A;
      end
      default: clr = 1'b1;
    endcase

    // Clear overrides whatever the state logic chose, including illegal-state recovery.
    if (clr) begin
      state_d  = S_A;
      a_d      = '0;
      b_d      = '0;
      mode_d   = '0;
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
      done_d   = 1'b0;
      cnt_d    = '0;
    end
  end

  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_mode = mode_q;
  assign bus.result   = result_q;
  assign bus.res_cout = cout_q;
  assign bus.res_ovf  = ovf_q;
  assign bus.done     = done_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: HOLD_CYCLES=2 and HOLD_CYCLES=1 instances share stimulus; a behavioural ALU feeds them.
module tb_alu_op_sequencer;
  localparam int H2 = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] sw;
  logic       btn_next, btn_clear;
  logic       ovr, ovr_c, ovr_v;
  logic [5:0] ovr_out;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: returns {ovf, cout, out}.
  function automatic logic [7:0] alu_model(input logic [5:0] a, input logic [5:0] b, input logic [2:0] m);
    logic [6:0] s;
    logic [5:0] o;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (m)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; o = s[5:0]; c = s[6]; v = (a[5] == b[5]) && (o[5] != a[5]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; o = s[5:0]; c = s[6]; v = (a[5] != b[5]) && (o[5] != a[5]); end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: o = ~a;
      3'd6: o = {a[4:0], 1'b0};
      default: o = a;
    endcase
    return {v, c, o};
  endfunction

  alu_op_sequencer_if #(.WIDTH(6), .MODE_W(3)) i2 ();
  alu_op_sequencer_if #(.WIDTH(6), .MODE_W(3)) i1 ();

  logic [7:0] f2, f1;
  assign f2 = alu_model(i2.alu_a, i2.alu_b, i2.alu_mode);
  assign f1 = alu_model(i1.alu_a, i1.alu_b, i1.alu_mode);

  assign i2.sw        = sw;
  assign i2.btn_next  = btn_next;
  assign i2.btn_clear = btn_clear;
  assign i2.alu_out   = ovr ? ovr_out : f2[5:0];
  assign i2.alu_cout  = ovr ? ovr_c   : f2[6];
  assign i2.alu_ovf   = ovr ? ovr_v   : f2[7];
  assign i1.sw        = sw;
  assign i1.btn_next  = btn_next;
  assign i1.btn_clear = btn_clear;
  assign i1.alu_out   = f1[5:0];
  assign i1.alu_cout  = f1[6];
  assign i1.alu_ovf   = f1[7];

  alu_op_sequencer #(.WIDTH(6), .MODE_W(3), .HOLD_CYCLES(H2)) u2 (.clk(clk), .reset(reset), .bus(i2.slave));
  alu_op_sequencer #(.WIDTH(6), .MODE_W(3), .HOLD_CYCLES(1))  u1 (.clk(clk), .reset(reset), .bus(i1.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next(input logic [5:0] v);
    sw = v;
    btn_next = 1'b1;
    step();
    btn_next = 1'b0;
  endtask

  task automatic pulse_clear();
    btn_clear = 1'b1;
    step();
    btn_clear = 1'b0;
  endtask

  task automatic run_ops(input logic [5:0] a, input logic [5:0] b, input logic [5:0] m);
    pulse_next(a);
    pulse_next(b);
    pulse_next(m);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({i2.state, i2.done, i2.alu_a, i2.alu_b, i2.alu_mode, i2.result, i2.res_cout, i2.res_ovf} !== '0) begin
      bad++;
      $display("FAIL reset_state: got state=%0d done=%0d a=%0d b=%0d mode=%0d res=%0d want all 0",
               i2.state, i2.done, i2.alu_a, i2.alu_b, i2.alu_mode, i2.result);
    end
    total++;
    if ({i1.state, i1.done} !== 4'd0) begin
      bad++;
      $display("FAIL reset_state_h1: got state=%0d done=%0d want 0 0", i1.state, i1.done);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_full_sequence();
    run_ops(6'd3, 6'd5, 6'd0);
    total++;
    if ({i2.state, i2.done, i2.alu_a, i2.alu_b, i2.alu_mode} !== {3'd3, 1'b0, 6'd3, 6'd5, 3'd0}) begin
      bad++;
      $display("FAIL seq_operands: got state=%0d done=%0d a=%0d b=%0d mode=%0d want 3 0 3 5 0",
               i2.state, i2.done, i2.alu_a, i2.alu_b, i2.alu_mode);
    end
    step();
    total++;
    if ({i2.state, i2.done} !== {3'd3, 1'b0}) begin
      bad++;
      $display("FAIL seq_settle: got state=%0d done=%0d want 3 0", i2.state, i2.done);
    end
    step();
    total++;
    if ({i2.state, i2.done, i2.result, i2.res_cout, i2.res_ovf} !== {3'd4, 1'b1, 6'd8, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL seq_capture: got state=%0d done=%0d res=%0d c=%0d v=%0d want 4 1 8 0 0",
               i2.state, i2.done, i2.result, i2.res_cout, i2.res_ovf);
    end
  endtask

  task automatic test_sample_not_live();
    pulse_next(6'd0);
    total++;
    if ({i2.state, i2.done, i2.result, i2.alu_a} !== {3'd0, 1'b0, 6'd8, 6'd3}) begin
      bad++;
      $display("FAIL show_exit: got state=%0d done=%0d res=%0d a=%0d want 0 0 8 3",
               i2.state, i2.done, i2.result, i2.alu_a);
    end
    run_ops(6'($urandom), 6'($urandom), 6'($urandom));
    ovr = 1'b1; ovr_out = 6'd63; ovr_c = 1'b1; ovr_v = 1'b1;
    repeat (H2) step();
    ovr_out = 6'd0; ovr_c = 1'b0; ovr_v = 1'b0;
    step();
    step();
    total++;
    if ({i2.state, i2.done, i2.result, i2.res_cout, i2.res_ovf} !== {3'd4, 1'b1, 6'd63, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL not_live: got state=%0d done=%0d res=%0d c=%0d v=%0d want 4 1 63 1 1",
               i2.state, i2.done, i2.result, i2.res_cout, i2.res_ovf);
    end
    ovr = 1'b0;
  endtask

  task automatic test_exec_ignore();
    logic [5:0] a, b, m;
    logic [7:0] e;
    a = 6'($urandom); b = 6'($urandom); m = 6'($urandom);
    e = alu_model(a, b, m[2:0]);
    pulse_next(6'd0);
    run_ops(a, b, m);
    btn_next = 1'b1;
    step();
    total++;
    if ({i2.state, i2.done} !== {3'd3, 1'b0}) begin
      bad++;
      $display("FAIL exec_ignore_1: got state=%0d done=%0d want 3 0", i2.state, i2.done);
    end
    step();
    total++;
    if ({i2.state, i2.done, i2.result} !== {3'd4, 1'b1, e[5:0]}) begin
      bad++;
      $display("FAIL exec_ignore_2: got state=%0d done=%0d res=%0d want 4 1 %0d", i2.state, i2.done, i2.result, e[5:0]);
    end
    step();
    btn_next = 1'b0;
    total++;
    if ({i2.state, i2.done, i2.alu_a, i2.alu_b, i2.alu_mode, i2.result} !== {3'd0, 1'b0, a, b, m[2:0], e[5:0]}) begin
      bad++;
      $display("FAIL show_next_retain: got state=%0d done=%0d a=%0d b=%0d mode=%0d res=%0d want 0 0 %0d %0d %0d %0d",
               i2.state, i2.done, i2.alu_a, i2.alu_b, i2.alu_mode, i2.result, a, b, m[2:0], e[5:0]);
    end
  endtask

  task automatic test_clear_priority();
    logic [5:0] a;
    a = 6'(1 + $urandom_range(62));
    pulse_clear();
    total++;
    if ({i2.state, i2.done, i2.alu_a, i2.alu_b, i2.alu_mode, i2.result, i2.res_cout, i2.res_ovf} !== '0) begin
      bad++;
      $display("FAIL clear_all: got state=%0d a=%0d b=%0d mode=%0d res=%0d want all 0",
               i2.state, i2.alu_a, i2.alu_b, i2.alu_mode, i2.result);
    end
    pulse_next(a);
    total++;
    if ({i2.state, i2.alu_a} !== {3'd1, a}) begin
      bad++;
      $display("FAIL clear_setup: got state=%0d a=%0d want 1 %0d", i2.state, i2.alu_a, a);
    end
    sw = 6'(1 + $urandom_range(62));
    btn_clear = 1'b1;
    btn_next = 1'b1;
    step();
    btn_clear = 1'b0;
    btn_next = 1'b0;
    total++;
    if ({i2.state, i2.alu_a, i2.alu_b} !== {3'd0, 6'd0, 6'd0}) begin
      bad++;
      $display("FAIL clear_priority: got state=%0d a=%0d b=%0d want 0 0 0", i2.state, i2.alu_a, i2.alu_b);
    end
  endtask

  task automatic test_reset_mid_exec();
    run_ops(6'(1 + $urandom_range(62)), 6'($urandom), 6'($urandom));
    repeat (H2) step();
    pulse_next(6'd0);
    run_ops(6'(1 + $urandom_range(62)), 6'(1 + $urandom_range(62)), 6'(1 + $urandom_range(6)));
    total++;
    if (i2.state !== 3'd3) begin
      bad++;
      $display("FAIL rst_exec_setup: got state=%0d want 3", i2.state);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({i2.state, i2.done, i2.alu_a, i2.alu_b, i2.alu_mode, i2.result, i2.res_cout, i2.res_ovf} !== '0) begin
      bad++;
      $display("FAIL rst_mid_exec: got state=%0d done=%0d a=%0d b=%0d mode=%0d res=%0d want all 0",
               i2.state, i2.done, i2.alu_a, i2.alu_b, i2.alu_mode, i2.result);
    end
    #2 reset = 1'b0;
  endtask

  task automatic test_hold1();
    logic [7:0] e;
    e = alu_model(6'd3, 6'd5, 3'd7);
    pulse_clear();
    run_ops(6'd3, 6'd5, 6'b000111);
    total++;
    if ({i1.state, i1.done, i1.alu_mode} !== {3'd3, 1'b0, 3'd7}) begin
      bad++;
      $display("FAIL h1_enter: got state=%0d done=%0d mode=%0d want 3 0 7", i1.state, i1.done, i1.alu_mode);
    end
    step();
    total++;
    if ({i1.state, i1.done, i1.result, i1.res_cout, i1.res_ovf} !== {3'd4, 1'b1, e[5:0], e[6], e[7]}) begin
      bad++;
      $display("FAIL h1_capture: got state=%0d done=%0d res=%0d want 4 1 %0d", i1.state, i1.done, i1.result, e[5:0]);
    end
    total++;
    if ({i2.state, i2.done} !== {3'd3, 1'b0}) begin
      bad++;
      $display("FAIL h2_still_exec: got state=%0d done=%0d want 3 0", i2.state, i2.done);
    end
    step();
  endtask

  task automatic test_random();
    logic [5:0] v[3];
    logic [7:0] e;
    logic [5:0] prev_res;
    pulse_clear();
    prev_res = '0;
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 3; k++) v[k] = 6'($urandom);
      e = alu_model(v[0], v[1], v[2][2:0]);
      for (int s = 0; s < 3; s++) begin
        repeat ($urandom_range(2)) begin
          step();
          total++;
          if ({i2.state, i2.result} !== {3'(s), prev_res}) begin
            bad++;
            $display("FAIL rnd_idle t=%0d: got state=%0d res=%0d want %0d %0d", t, i2.state, i2.result, s, prev_res);
          end
        end
        pulse_next(v[s]);
      end
      btn_next = 1'($urandom);
      for (int c = 1; c < H2; c++) begin
        step();
        total++;
        if ({i2.state, i2.done} !== {3'd3, 1'b0}) begin
          bad++;
          $display("FAIL rnd_exec t=%0d: got state=%0d done=%0d want 3 0", t, i2.state, i2.done);
        end
      end
      step();
      btn_next = 1'b0;
      total++;
      if ({i2.state, i2.done, i2.alu_a, i2.alu_b, i2.alu_mode, i2.result, i2.res_cout, i2.res_ovf} !==
          {3'd4, 1'b1, v[0], v[1], v[2][2:0], e[5:0], e[6], e[7]}) begin
        bad++;
        $display("FAIL rnd_result t=%0d: got state=%0d a=%0d b=%0d mode=%0d res=%0d c=%0d v=%0d want 4 %0d %0d %0d %0d %0d %0d",
                 t, i2.state, i2.alu_a, i2.alu_b, i2.alu_mode, i2.result, i2.res_cout, i2.res_ovf,
                 v[0], v[1], v[2][2:0], e[5:0], e[6], e[7]);
      end
      repeat ($urandom_range(2)) step();
      pulse_next(6'($urandom));
      total++;
      if ({i2.state, i2.done, i2.result} !== {3'd0, 1'b0, e[5:0]}) begin
        bad++;
        $display("FAIL rnd_return t=%0d: got state=%0d done=%0d res=%0d want 0 0 %0d", t, i2.state, i2.done, i2.result, e[5:0]);
      end
      prev_res = e[5:0];
    end
  endtask

  initial begin
    reset = 1'b1;
    sw = '0;
    btn_next = 1'b0;
    btn_clear = 1'b0;
    ovr = 1'b0;
    ovr_out = '0;
    ovr_c = 1'b0;
    ovr_v = 1'b0;
    test_reset();
    test_full_sequence();
    test_sample_not_live();
    test_exec_ignore();
    test_clear_priority();
    test_reset_mid_exec();
    test_hold1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
